avmm_param_regs: RTL

Avalon-MM slave register bank that sits directly downstream of the SPI-to-Avalon-MM bridge (`avmm_as_spisram`). It lets an external SPI host stage Mandelbrot rendering parameters into shadow registers, then commit them atomically to the accelerator core. A commit waits until the core is idle, copies shadow to active, and pulses a start strobe. Reads return shadow/status words with a fixed pipelined latency through `readdatavalid`.

---
 rtl/avmm_param_regs_pkg.sv | 24 ++
 rtl/avmm_param_regs_if.sv | 23 ++
 rtl/avmm_param_regs_rdpipe.sv | 35 +++
 rtl/avmm_param_regs.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/avmm_param_regs_pkg.sv
// Shared types and constants for the Avalon-MM parameter register bank.
// Slot indices are word indices (byte address >> 2).
package avmm_param_regs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_START   = 2'd2
  } state_e;

  localparam int REG_CTRL   = 0;
  localparam int REG_STATUS = 1;
  localparam int REG_PARAM0 = 2;

  localparam int CTRL_COMMIT_BIT   = 0;
  localparam int CTRL_CLR_DONE_BIT = 1;

  localparam int STAT_ACTIVE_BIT = 0;
  localparam int STAT_BUSY_BIT   = 1;
  localparam int STAT_DONE_BIT   = 2;
  localparam int STAT_CNT_LSB    = 16;
  localparam int STAT_CNT_W      = 8;

endpackage

// File: rtl/avmm_param_regs_if.sv
// Avalon-MM slave-side bus bundle between the SPI bridge and the register bank.
interface avmm_param_regs_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] mem_writedata;
  logic [DATA_WIDTH-1:0] mem_readdata;
  logic                  mem_readdatavalid;
  logic                  mem_waitrequest;

  modport master (
    output mem_address, mem_read, mem_write, mem_writedata,
    input  mem_readdata, mem_readdatavalid, mem_waitrequest
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_writedata,
    output mem_readdata, mem_readdatavalid, mem_waitrequest
  );
endinterface

// File: rtl/avmm_param_regs_rdpipe.sv
// Fixed-latency read-return delay line carrying {valid, data}.
// Data is zeroed on non-valid stages so readdata idles at 0.
module avmm_param_regs_rdpipe #(
  parameter int READ_LATENCY = 2,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  sys_clk,
  input  logic                  sys_rstn,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [READ_LATENCY-1:0]                 valid_q;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] data_q;

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q[0] <= in_valid;
      data_q[0]  <= in_valid ? in_data : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[READ_LATENCY-1];
  assign out_data  = data_q[READ_LATENCY-1];

endmodule

// File: rtl/avmm_param_regs.sv
// Shadow/active parameter register bank with atomic commit to the render core.
//
//   state      | meaning
//   ST_IDLE    | no commit in flight; commit writes accepted
//   ST_PENDING | commit requested; waiting for core_busy low, copy on exit
//   ST_START   | core_start high this cycle; commit counter bumps on exit
module avmm_param_regs
  import avmm_param_regs_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGS     = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic                               sys_clk,
  input  logic                               sys_rstn,
  avmm_param_regs_if.slave                   avmm,
  input  logic                               core_busy,
  input  logic                               core_done,
  output logic                               core_start,
  output logic [(NUM_REGS-2)*DATA_WIDTH-1:0] param_active
);

  localparam int WORD_W = ADDR_WIDTH - 2;

  state_e                                          state_q;
  logic [STAT_CNT_W-1:0]                           commit_cnt_q;
  logic                                            done_q;
  logic [NUM_REGS-1:REG_PARAM0][DATA_WIDTH-1:0]    shadow_q;
  logic [NUM_REGS-1:REG_PARAM0][DATA_WIDTH-1:0]    active_q;

  logic [WORD_W-1:0]     word_idx;
  logic                  is_ctrl;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  commit_req;
  logic                  clr_done;
  logic [DATA_WIDTH-1:0] status_word;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  unused_addr_lsbs;

  assign word_idx         = avmm.mem_address[ADDR_WIDTH-1:2];
  assign unused_addr_lsbs = ^avmm.mem_address[1:0];
  assign is_ctrl          = (word_idx == WORD_W'(REG_CTRL));

  // Only a second commit can stall; it is held until the FSM is back in IDLE.
  assign avmm.mem_waitrequest = avmm.mem_write && is_ctrl &&
                                avmm.mem_writedata[CTRL_COMMIT_BIT] &&
                                (state_q != ST_IDLE);

  assign wr_acc     = avmm.mem_write && !avmm.mem_waitrequest;
  assign rd_acc     = avmm.mem_read && !avmm.mem_write && !avmm.mem_waitrequest;
  assign commit_req = wr_acc && is_ctrl && avmm.mem_writedata[CTRL_COMMIT_BIT];
  assign clr_done   = wr_acc && is_ctrl && avmm.mem_writedata[CTRL_CLR_DONE_BIT];

  always_comb begin
    status_word                                  = '0;
    status_word[STAT_ACTIVE_BIT]                 = (state_q != ST_IDLE);
    status_word[STAT_BUSY_BIT]                   = core_busy;
    status_word[STAT_DONE_BIT]                   = done_q;
    status_word[STAT_CNT_LSB +: STAT_CNT_W]      = commit_cnt_q;
  end

  // CTRL and out-of-range slots fall through to zero.
  always_comb begin
    rd_data = '0;
    if (word_idx == WORD_W'(REG_STATUS)) begin
      rd_data = status_word;
    end
    for (int i = REG_PARAM0; i < NUM_REGS; i++) begin
      if (word_idx == WORD_W'(i)) begin
        rd_data = shadow_q[i];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      shadow_q <= '0;
    end else begin
      for (int i = REG_PARAM0; i < NUM_REGS; i++) begin
        if (wr_acc && (word_idx == WORD_W'(i))) begin
          shadow_q[i] <= avmm.mem_writedata;
        end
      end
    end
  end

  // A done pulse wins over a simultaneous clear.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      done_q <= 1'b0;
    end else if (core_done) begin
      done_q <= 1'b1;
    end else if (clr_done) begin
      done_q <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q      <= ST_IDLE;
      core_start   <= 1'b0;
      commit_cnt_q <= '0;
      active_q     <= '0;
    end else begin
      core_start <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (commit_req) begin
            state_q <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (!core_busy) begin
            active_q   <= shadow_q;
            core_start <= 1'b1;
            state_q    <= ST_START;
          end
        end
        ST_START: begin
          commit_cnt_q <= commit_cnt_q + 1'b1;
          state_q      <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign param_active = active_q;

  avmm_param_regs_rdpipe #(
    .READ_LATENCY (READ_LATENCY),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_rdpipe (
    .sys_clk   (sys_clk),
    .sys_rstn  (sys_rstn),
    .in_valid  (rd_acc),
    .in_data   (rd_data),
    .out_valid (avmm.mem_readdatavalid),
    .out_data  (avmm.mem_readdata)
  );

endmodule
